// File: rtl/mesh_eject_port_if.sv
// Packet types and the network/sink-facing handshake bundle for the mesh ejection port.
// The network side drives pkt_in and sees full; the sink side drives drain_en and sees pkt_out.
package mesh_eject_pkg;

  typedef struct packed {
    logic        valid;
    logic [7:0]  source;
    logic [3:0]  xdest;
    logic [3:0]  ydest;
    logic [31:0] data;
    logic [4:0]  hopCount;
    logic        reroute;
    logic        measure;
  } packet_mesh;

  typedef struct packed {
    logic        valid;
    logic [7:0]  source;
    logic [7:0]  dest;
    logic [31:0] data;
    logic [4:0]  hopCount;
    logic        reroute;
    logic        measure;
  } packet_t;

endpackage

interface mesh_eject_port_if;
  import mesh_eject_pkg::*;

  packet_mesh pkt_in;
  logic       full;
  logic       drain_en;
  packet_t    pkt_out;

  modport master (output pkt_in, output drain_en, input full, input pkt_out);
  modport slave  (input pkt_in, input drain_en, output full, output pkt_out);

endinterface

// File: rtl/mesh_eject_port.sv
// Ejection buffer at a mesh local output: FIFO with registered backpressure, xy->numbered
// destination conversion, rate-limited drain, destination check and delivery statistics.
module mesh_eject_port
  import mesh_eject_pkg::*;
#(
  parameter int PORT_ID      = 0,
  parameter int MESH_WIDTH   = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int DRAIN_PERIOD = 1,
  parameter int TS_WIDTH     = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  mesh_eject_port_if.slave    eject_if,
  input  logic [TS_WIDTH-1:0] timestamp_i,
  output logic [15:0]         pkt_count_o,
  output logic [31:0]         latency_sum_o,
  output logic [20:0]         hop_sum_o,
  output logic                dest_error_o,
  output logic [15:0]         error_count_o,
  output logic                overflow_error_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = (DRAIN_PERIOD > 1) ? $clog2(DRAIN_PERIOD) : 1;
  localparam logic [3:0]    X_ID         = 4'(PORT_ID % MESH_WIDTH);
  localparam logic [3:0]    Y_ID         = 4'(PORT_ID / MESH_WIDTH);
  localparam logic [AW:0]   DEPTH        = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_MARK    = (AW+1)'(FIFO_DEPTH - 1);
  localparam logic [DW-1:0] DRAIN_RELOAD = DW'(DRAIN_PERIOD - 1);

  packet_mesh mem_q [FIFO_DEPTH];
  packet_mesh head;
  packet_t    pkt_out_q, pkt_out_d;

  logic [AW:0]         wr_ptr_q, rd_ptr_q, occ, occ_d;
  logic [DW-1:0]       drain_q;
  logic                full_q;
  logic                do_rd, do_wr, drop, dest_bad;
  logic [TS_WIDTH-1:0] lat;
  logic [32:0]         lat_sum_ext;
  logic [21:0]         hop_sum_ext;
  logic [15:0]         pkt_count_q, error_count_q;
  logic [31:0]         latency_sum_q;
  logic [20:0]         hop_sum_q;
  logic                dest_error_q, overflow_error_q;

  // Pointers carry one extra bit so their difference is the true occupancy 0..FIFO_DEPTH.
  assign occ  = wr_ptr_q - rd_ptr_q;
  assign head = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_rd    = (occ != '0) && eject_if.drain_en && (drain_q == '0);
    do_wr    = eject_if.pkt_in.valid && ((occ != DEPTH) || do_rd);
    drop     = eject_if.pkt_in.valid && (occ == DEPTH) && !do_rd;
    dest_bad = eject_if.pkt_in.valid &&
               ((eject_if.pkt_in.xdest != X_ID) || (eject_if.pkt_in.ydest != Y_ID));
    occ_d    = occ + (AW+1)'(do_wr) - (AW+1)'(do_rd);

    lat         = timestamp_i - head.data[TS_WIDTH-1:0];
    lat_sum_ext = {1'b0, latency_sum_q} + 33'(lat);
    hop_sum_ext = {1'b0, hop_sum_q} + 22'(head.hopCount);

    pkt_out_d          = '0;
    pkt_out_d.valid    = head.valid;
    pkt_out_d.source   = head.source;
    pkt_out_d.dest     = 8'(head.ydest) * 8'(MESH_WIDTH) + 8'(head.xdest);
    pkt_out_d.data     = head.data;
    pkt_out_d.hopCount = head.hopCount;
    pkt_out_d.reroute  = head.reroute;
    pkt_out_d.measure  = head.measure;
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= eject_if.pkt_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      drain_q          <= '0;
      full_q           <= 1'b0;
      pkt_out_q        <= '0;
      pkt_count_q      <= '0;
      latency_sum_q    <= '0;
      hop_sum_q        <= '0;
      error_count_q    <= '0;
      dest_error_q     <= 1'b0;
      overflow_error_q <= 1'b0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      full_q <= (occ_d >= FULL_MARK);
      if (drop) overflow_error_q <= 1'b1;
      if (dest_bad) begin
        dest_error_q <= 1'b1;
        if (error_count_q != '1) error_count_q <= error_count_q + 1'b1;
      end

      if (do_rd) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        drain_q   <= DRAIN_RELOAD;
        pkt_out_q <= pkt_out_d;
        if (pkt_count_q != '1) pkt_count_q <= pkt_count_q + 1'b1;
        if (head.measure) begin
          latency_sum_q <= lat_sum_ext[32] ? '1 : lat_sum_ext[31:0];
          hop_sum_q     <= hop_sum_ext[21] ? '1 : hop_sum_ext[20:0];
        end
      end else begin
        pkt_out_q.valid <= 1'b0;
        if (drain_q != '0) drain_q <= drain_q - 1'b1;
      end
    end
  end

  assign eject_if.full    = full_q;
  assign eject_if.pkt_out = pkt_out_q;

  assign pkt_count_o      = pkt_count_q;
  assign latency_sum_o    = latency_sum_q;
  assign hop_sum_o        = hop_sum_q;
  assign dest_error_o     = dest_error_q;
  assign error_count_o    = error_count_q;
  assign overflow_error_o = overflow_error_q;

endmodule
